aes_key_sched: RTL and testbench

// - Iterative AES key-expansion responder for the key-load request (func=1) of the aes_in/aes_out protocol.
// - Accepts a cipher key and generates the full FIPS-197 schedule, one 32-bit word per cycle.
// - Pulses ready when the schedule is complete, then serves round keys through a read port to the round datapath.
// - Sits beside the round datapath inside the AES core and replaces per-round on-the-fly expansion.

---
 rtl/aes_key_sched_pkg.sv | 61 ++++++
 rtl/aes_key_sched_sub_word.sv | 17 +
 rtl/aes_key_sched.sv | 123 ++++++++++++
 tb/tb_aes_key_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/aes_key_sched_pkg.sv
// Shared constants, types and byte-level helpers for the AES key-schedule block.
package aes_key_sched_pkg;

    localparam int unsigned NB     = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned RK_W   = NB * WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_t;

    typedef struct packed {
        logic ready;
        logic busy;
        logic key_valid;
    } ks_status_t;

    // Forward S-box; entry b sits at bits [2047-8*b -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] msb;
        msb = 11'd2047 - {b, 3'b000};
        return SBOX_TABLE[msb -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] x);
        return {x[23:0], x[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_sched_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
module aes_key_sched_sub_word
    import aes_key_sched_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub_c
);

    // Four independent byte lookups.
    always_comb begin
        sub_c = '0;
        for (int b = 0; b < 4; b++) begin
            sub_c[8*b +: 8] = sbox(word[8*b +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES key expansion: one schedule word per cycle, round keys served by a mux.
module aes_key_sched
    import aes_key_sched_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           func,
    input  logic [32*NK-1:0]     key,
    output logic                 ready,
    output logic                 busy,
    output logic                 key_valid,
    input  logic [3:0]           rk_addr,
    output logic [RK_W-1:0]      rk_data
);

    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = NB * (NR + 1);

    ks_state_t         state, state_next;
    ks_status_t        status, status_next;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] w [NW];
    logic              load, last;
    logic [IDX_W-1:0]  idx_mod, idx_div;
    logic [WORD_W-1:0] prev, back, sub_src, sub_c, temp, new_word;

    assign load      = enable && (func == 2'd1);
    assign last      = (idx == IDX_W'(NW - 1));
    assign ready     = status.ready;
    assign busy      = status.busy;
    assign key_valid = status.key_valid;

    assign prev    = w[idx - IDX_W'(1)];
    assign back    = w[idx - IDX_W'(NK)];
    assign idx_mod = idx % IDX_W'(NK);
    assign idx_div = idx / IDX_W'(NK);
    assign sub_src = (idx_mod == '0) ? rot_word(prev) : prev;

    aes_key_sched_sub_word u_sub_word (
        .word  (sub_src),
        .sub_c (sub_c)
    );

    // Recurrence for w[idx]; the extra SubWord step only exists for 256-bit keys.
    always_comb begin
        temp = prev;
        if (idx_mod == '0) begin
            temp = sub_c ^ {rcon(4'(idx_div)), 24'h0};
        end else if ((NK == 8) && (idx_mod == IDX_W'(4))) begin
            temp = sub_c;
        end
        new_word = back ^ temp;
    end

    // Next state and next registered status flags.
    always_comb begin
        state_next        = state;
        status_next       = status;
        status_next.ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_next            = ST_GEN;
                    status_next.busy      = 1'b1;
                    status_next.key_valid = 1'b0;
                end
            end
            ST_GEN: begin
                if (last) begin
                    state_next            = ST_DONE;
                    status_next.busy      = 1'b0;
                    status_next.ready     = 1'b1;
                    status_next.key_valid = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            status <= '0;
        end else begin
            state  <= state_next;
            status <= status_next;
        end
    end

    // Schedule storage: key words on load, one derived word per GEN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            for (int k = 0; k < NW; k++) begin
                w[k] <= '0;
            end
        end else if ((state == ST_IDLE) && load) begin
            for (int k = 0; k < NK; k++) begin
                w[k] <= key[32*(NK-k)-1 -: 32];
            end
            idx <= IDX_W'(NK);
        end else if (state == ST_GEN) begin
            w[idx] <= new_word;
            idx    <= idx + IDX_W'(1);
        end
    end

    // Round-key read mux; out-of-range rounds read as zero.
    always_comb begin
        rk_data = '0;
        if (rk_addr <= 4'(NR)) begin
            for (int k = 0; k < 4; k++) begin
                rk_data[RK_W-1-32*k -: 32] = w[{rk_addr, 2'b00} + IDX_W'(k)];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched with AES-128 and AES-256 instances.
module tb_aes_key_sched;

    logic         clk;
    logic         rst;
    logic         enable4, enable8;
    logic [1:0]   func4, func8;
    logic [127:0] key4;
    logic [255:0] key8;
    logic [3:0]   rk_addr4, rk_addr8;
    logic         ready4, busy4, kv4;
    logic         ready8, busy8, kv8;
    logic [127:0] rk4, rk8;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY256   =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_sched #(.NK(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable4), .func(func4), .key(key4),
        .ready(ready4), .busy(busy4), .key_valid(kv4),
        .rk_addr(rk_addr4), .rk_data(rk4)
    );

    aes_key_sched #(.NK(8)) dut8 (
        .clk(clk), .rst(rst), .enable(enable8), .func(func8), .key(key8),
        .ready(ready8), .busy(busy8), .key_valid(kv8),
        .rk_addr(rk_addr8), .rk_data(rk8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic read_rk(input bit sel8, input logic [3:0] addr, output logic [127:0] d);
        if (sel8) rk_addr8 = addr; else rk_addr4 = addr;
        #1;
        d = sel8 ? rk8 : rk4;
    endtask

    // Issue a key load, optionally inject a second load n cycles into GEN, and time ready.
    task automatic run_load(input bit sel8, input logic [255:0] k, input int inject,
                            input logic [255:0] alt, output int cycles, output int busy_cnt);
        int n;
        @(negedge clk);
        if (sel8) begin enable8 = 1'b1; func8 = 2'd1; key8 = k; end
        else      begin enable4 = 1'b1; func4 = 2'd1; key4 = k[127:0]; end
        @(posedge clk); #1;
        enable4 = 1'b0; enable8 = 1'b0;
        n = 0;
        busy_cnt = (sel8 ? busy8 : busy4) ? 1 : 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            enable4 = 1'b0; enable8 = 1'b0;
            if (sel8 ? ready8 : ready4) break;
            if (sel8 ? busy8 : busy4) busy_cnt++;
            if (n == inject) begin
                if (sel8) begin enable8 = 1'b1; func8 = 2'd1; key8 = alt; end
                else      begin enable4 = 1'b1; func4 = 2'd1; key4 = alt[127:0]; end
            end
        end
        cycles = n + 1;
        check("busy_at_ready", sel8 ? busy8 : busy4, 0);
        check("kv_at_ready", sel8 ? kv8 : kv4, 1);
        @(posedge clk); #1;
        check("ready_one_cycle", sel8 ? ready8 : ready4, 0);
        check("kv_after_ready", sel8 ? kv8 : kv4, 1);
    endtask

    initial begin
        logic [127:0] d;
        int cyc, bc;

        rst = 1'b1;
        enable4 = 1'b0; enable8 = 1'b0;
        func4 = 2'd0; func8 = 2'd0;
        key4 = '0; key8 = '0;
        rk_addr4 = '0; rk_addr8 = '0;
        #1;
        check("rst_ready", ready4, 0);
        check("rst_busy", busy4, 0);
        check("rst_kv", kv4, 0);
        read_rk(1'b0, 4'd0, d);
        check("rst_rk0", d, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Non-key request before any load leaves key_valid low.
        enable4 = 1'b1; func4 = 2'd2;
        @(posedge clk); #1;
        enable4 = 1'b0;
        check("func2_idle_busy", busy4, 0);
        check("func2_idle_kv", kv4, 0);

        // FIPS-197 AES-128 example.
        run_load(1'b0, {128'h0, FIPS_KEY}, 0, '0, cyc, bc);
        check("fips128_latency", cyc, 41);
        check("fips128_busy_cycles", bc, 40);
        read_rk(1'b0, 4'd0, d);  check("fips128_rk0", d, FIPS_KEY);
        read_rk(1'b0, 4'd1, d);  check("fips128_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(1'b0, 4'd10, d); check("fips128_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Second request mid-GEN is ignored.
        run_load(1'b0, {128'h0, FIPS_KEY}, 5, {128'h0, {128{1'b1}}}, cyc, bc);
        check("ignore_latency", cyc, 41);
        read_rk(1'b0, 4'd1, d);  check("ignore_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(1'b0, 4'd10, d); check("ignore_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // All-zero key.
        run_load(1'b0, '0, 0, '0, cyc, bc);
        check("zero_latency", cyc, 41);
        read_rk(1'b0, 4'd0, d);  check("zero_rk0", d, 0);
        read_rk(1'b0, 4'd1, d);  check("zero_rk1", d, 128'h62636363626363636263636362636363);
        read_rk(1'b0, 4'd10, d); check("zero_rk10", d, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        read_rk(1'b0, 4'd11, d); check("zero_rk11", d, 0);
        read_rk(1'b0, 4'd15, d); check("zero_rk15", d, 0);

        // Non-key funcs and disabled key func in IDLE change nothing.
        @(negedge clk); enable4 = 1'b1; func4 = 2'd2;
        @(posedge clk); #1; check("func2_busy", busy4, 0);
        @(negedge clk); func4 = 2'd3;
        @(posedge clk); #1; check("func3_busy", busy4, 0);
        @(negedge clk); enable4 = 1'b0; func4 = 2'd1; key4 = FIPS_KEY;
        @(posedge clk); #1; check("noen_busy", busy4, 0);
        @(posedge clk); #1;
        check("func_kv_kept", kv4, 1);
        read_rk(1'b0, 4'd10, d); check("func_rk10_kept", d, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Reset in the middle of GEN.
        @(negedge clk); enable4 = 1'b1; func4 = 2'd1; key4 = FIPS_KEY;
        @(posedge clk); #1; enable4 = 1'b0;
        check("load_clears_kv", kv4, 0);
        repeat (20) @(posedge clk);
        #1;
        check("midop_busy_before", busy4, 1);
        rst = 1'b1;
        #1;
        check("midop_busy", busy4, 0);
        check("midop_ready", ready4, 0);
        check("midop_kv", kv4, 0);
        read_rk(1'b0, 4'd0, d); check("midop_rk0", d, 0);
        @(negedge clk); rst = 1'b0;
        run_load(1'b0, {128'h0, FIPS_KEY}, 0, '0, cyc, bc);
        check("after_rst_latency", cyc, 41);
        read_rk(1'b0, 4'd10, d); check("after_rst_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // FIPS-197 AES-256 example.
        run_load(1'b1, KEY256, 0, '0, cyc, bc);
        check("fips256_latency", cyc, 53);
        check("fips256_busy_cycles", bc, 52);
        read_rk(1'b1, 4'd0, d);  check("fips256_rk0", d, 128'h603deb1015ca71be2b73aef0857d7781);
        read_rk(1'b1, 4'd1, d);  check("fips256_rk1", d, 128'h1f352c073b6108d72d9810a30914dff4);
        read_rk(1'b1, 4'd2, d);  check("fips256_rk2", d, 128'h9ba354118e6925afa51a8b5f2067fcde);
        read_rk(1'b1, 4'd14, d); check("fips256_rk14", d, 128'hfe4890d1e6188d0b046df344706c631e);
        read_rk(1'b1, 4'd15, d); check("fips256_rk15", d, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
